// File: rtl/sr_cmd_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sr_cmd_conditioner
// Description : Synchronizes and debounces raw set/reset buttons and issues
//               one-cycle S/R commands, blocking same-cycle presses.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_btn,
    input  logic             reset_btn,
    output logic             S,
    output logic             R,
    output logic             conflict,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] reset_cnt
);

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] btn;
    logic [1:0] press;

    // Channel 0 is set, channel 1 is reset.
    assign btn = {reset_btn, set_btn};

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            logic            sync1;
            logic            sync2;
            logic            db;
            logic            db_d;
            logic [DB_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                    db    <= 1'b0;
                    db_d  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    sync1 <= btn[ch];
                    sync2 <= sync1;
                    db_d  <= db;
                    // Any return to the settled level restarts the qualification window.
                    if (sync2 == db) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        db  <= sync2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign press[ch] = db & ~db_d;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            S         <= 1'b0;
            R         <= 1'b0;
            conflict  <= 1'b0;
            set_cnt   <= '0;
            reset_cnt <= '0;
        end else begin
            S        <= press[0] & ~press[1];
            R        <= press[1] & ~press[0];
            conflict <= press[0] & press[1];
            if (S && (set_cnt != CNT_MAX)) begin
                set_cnt <= set_cnt + 1'b1;
            end
            if (R && (reset_cnt != CNT_MAX)) begin
                reset_cnt <= reset_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_cmd_conditioner
// Description : Directed self-checking bench for sr_cmd_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sr_cmd_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_btn;
    logic       reset_btn;
    logic       S;
    logic       R;
    logic       conflict;
    logic [7:0] set_cnt;
    logic [7:0] reset_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_set = 8'd0;
    logic [7:0] exp_rst = 8'd0;

    always #5 clk = ~clk;

    sr_cmd_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_btn  (set_btn),
        .reset_btn(reset_btn),
        .S        (S),
        .R        (R),
        .conflict (conflict),
        .set_cnt  (set_cnt),
        .reset_cnt(reset_cnt)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; set_btn = 1'b0; reset_btn = 1'b0;
        #1;
        n_checks++;
        if ({S, R, conflict, set_cnt, reset_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async_t0: got S=%b R=%b conflict=%b set_cnt=%0d reset_cnt=%0d, want all 0",
                     S, R, conflict, set_cnt, reset_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            set_btn = i[0]; reset_btn = ~i[0];
            n_checks++;
            if ({S, R, conflict, set_cnt, reset_cnt} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got S=%b R=%b conflict=%b set_cnt=%0d reset_cnt=%0d, want all 0",
                         i, S, R, conflict, set_cnt, reset_cnt);
            end
        end
        set_btn = 1'b0; reset_btn = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_clean_press();
        set_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();  // outputs after edge k+i
            n_checks++;
            if (S !== (i == 6) || R !== 1'b0 || conflict !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_press[%0d]: got S=%b R=%b conflict=%b, want S=%b R=0 conflict=0",
                         i, S, R, conflict, (i == 6));
            end
            n_checks++;
            if (set_cnt !== ((i >= 7) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL clean_cnt[%0d]: got set_cnt=%0d, want %0d", i, set_cnt, (i >= 7) ? 1 : 0);
            end
        end
        exp_set = 8'd1;
        set_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (S !== 1'b0 || R !== 1'b0 || set_cnt !== exp_set) begin
                n_fail++;
                $display("FAIL clean_release[%0d]: got S=%b R=%b set_cnt=%0d, want S=0 R=0 set_cnt=%0d",
                         i, S, R, set_cnt, exp_set);
            end
        end
    endtask

    task automatic test_bounce();
        for (int w = 1; w <= 3; w++) begin
            reset_btn = 1'b1;
            for (int i = 0; i < w; i++) tick();
            reset_btn = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                n_checks++;
                if (R !== 1'b0 || reset_cnt !== 8'd0) begin
                    n_fail++;
                    $display("FAIL bounce_w%0d[%0d]: got R=%b reset_cnt=%0d, want R=0 reset_cnt=0",
                             w, i, R, reset_cnt);
                end
            end
        end
        reset_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_checks++;
            if (R !== (i == 6) || S !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_hold[%0d]: got R=%b S=%b, want R=%b S=0", i, R, S, (i == 6));
            end
            n_checks++;
            if (reset_cnt !== ((i >= 7) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL bounce_cnt[%0d]: got reset_cnt=%0d, want %0d", i, reset_cnt, (i >= 7) ? 1 : 0);
            end
        end
        exp_rst = 8'd1;
        reset_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_simultaneous();
        set_btn = 1'b1; reset_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_checks++;
            if (conflict !== (i == 6) || S !== 1'b0 || R !== 1'b0) begin
                n_fail++;
                $display("FAIL simul[%0d]: got conflict=%b S=%b R=%b, want conflict=%b S=0 R=0",
                         i, conflict, S, R, (i == 6));
            end
            n_checks++;
            if (set_cnt !== exp_set || reset_cnt !== exp_rst) begin
                n_fail++;
                $display("FAIL simul_cnt[%0d]: got set_cnt=%0d reset_cnt=%0d, want %0d %0d",
                         i, set_cnt, reset_cnt, exp_set, exp_rst);
            end
        end
        set_btn = 1'b0; reset_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_staggered();
        set_btn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) reset_btn = 1'b1;
            n_checks++;
            if (S !== (i == 6) || R !== (i == 7) || conflict !== 1'b0) begin
                n_fail++;
                $display("FAIL stagger[%0d]: got S=%b R=%b conflict=%b, want S=%b R=%b conflict=0",
                         i, S, R, conflict, (i == 6), (i == 7));
            end
        end
        exp_set = exp_set + 8'd1;
        exp_rst = exp_rst + 8'd1;
        n_checks++;
        if (set_cnt !== exp_set || reset_cnt !== exp_rst) begin
            n_fail++;
            $display("FAIL stagger_cnt: got set_cnt=%0d reset_cnt=%0d, want %0d %0d",
                     set_cnt, reset_cnt, exp_set, exp_rst);
        end
        set_btn = 1'b0; reset_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_saturation();
        int total = 0;
        for (int p = 0; p < 300; p++) begin
            int seen = 0;
            set_btn = 1'b1;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (S === 1'b1) seen++;
            end
            set_btn = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (S === 1'b1) seen++;
            end
            total += seen;
            n_checks++;
            if (seen != 1) begin
                n_fail++;
                $display("FAIL sat_pulse[%0d]: got %0d S pulses, want 1", p, seen);
            end
        end
        n_checks++;
        if (total != 300) begin
            n_fail++;
            $display("FAIL sat_total: got %0d S pulses, want 300", total);
        end
        exp_set = 8'd255;
        n_checks++;
        if (set_cnt !== exp_set || reset_cnt !== exp_rst) begin
            n_fail++;
            $display("FAIL sat_cnt: got set_cnt=%0d reset_cnt=%0d, want 255 %0d", set_cnt, reset_cnt, exp_rst);
        end
    endtask

    task automatic test_reset_mid_press();
        set_btn = 1'b1;
        for (int i = 0; i < 6; i++) tick();  // db has flipped at edge k+5
        rst = 1'b0;
        #1;
        n_checks++;
        if ({S, R, conflict, set_cnt, reset_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got S=%b R=%b conflict=%b set_cnt=%0d reset_cnt=%0d, want all 0",
                     S, R, conflict, set_cnt, reset_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (S !== 1'b0 || set_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_hold[%0d]: got S=%b set_cnt=%0d, want 0 0", i, S, set_cnt);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();  // outputs after edge j+i, j = first edge with rst high
            n_checks++;
            if (S !== (i == 6) || R !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_press[%0d]: got S=%b R=%b, want S=%b R=0", i, S, R, (i == 6));
            end
            n_checks++;
            if (set_cnt !== ((i >= 7) ? 8'd1 : 8'd0) || reset_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_cnt[%0d]: got set_cnt=%0d reset_cnt=%0d, want %0d 0",
                         i, set_cnt, reset_cnt, (i >= 7) ? 1 : 0);
            end
        end
        set_btn = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_staggered();
        test_saturation();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
